// File: rtl/lcd8080_pkg.sv
// Shared types and constants for the 8080-style LCD bus controller.
package lcd8080_pkg;

    typedef enum logic [2:0] {
        RST_LO,
        RST_WT,
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI
    } lcd_state_e;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Sizes the phase counter from the longest of the timing parameters.
    function automatic int max_timing(input int a, input int b, input int c,
                                      input int d, input int e, input int f);
        return max2(max2(max2(a, b), max2(c, d)), max2(e, f));
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Down-counter that times one bus phase: load (length-1), done when it reaches zero.
module lcd_phase_timer
    import lcd8080_pkg::*;
#(
    parameter int            CW      = 4,
    parameter logic [CW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Reset value times the panel reset-low phase that starts at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus8080.sv
// 8080-style parallel LCD bus master: panel reset sequence, burst writes, single reads.
module lcd_bus8080
    import lcd8080_pkg::*;
#(
    parameter int DW       = 16,
    parameter int WR_LOW   = 2,
    parameter int WR_HIGH  = 2,
    parameter int RD_LOW   = 4,
    parameter int RD_HIGH  = 4,
    parameter int RST_LOW  = 10,
    parameter int RST_WAIT = 20,
    parameter int REP_W    = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rs,
    input  logic             cmd_rd,
    input  logic [DW-1:0]    cmd_data,
    input  logic [REP_W-1:0] cmd_rep,
    output logic             rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             init_done,
    output logic             lcd_cs_n,
    output logic             lcd_rs,
    output logic             lcd_wr_n,
    output logic             lcd_rd_n,
    output logic             lcd_rst_n,
    output logic [DW-1:0]    lcd_db_out,
    output logic             lcd_db_oe,
    input  logic [DW-1:0]    lcd_db_in
);

    localparam int MAXT = max_timing(WR_LOW, WR_HIGH, RD_LOW, RD_HIGH, RST_LOW, RST_WAIT);
    localparam int CW   = $clog2(MAXT) + 1;

    localparam logic [CW-1:0] LD_RST_LO = CW'(RST_LOW - 1);
    localparam logic [CW-1:0] LD_RST_WT = CW'(RST_WAIT - 1);
    localparam logic [CW-1:0] LD_WR_LO  = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] LD_WR_HI  = CW'(WR_HIGH - 1);
    localparam logic [CW-1:0] LD_RD_LO  = CW'(RD_LOW - 1);
    localparam logic [CW-1:0] LD_RD_HI  = CW'(RD_HIGH - 1);

    lcd_state_e       state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             init_done_q, init_done_d;
    logic             lcd_cs_n_q, lcd_cs_n_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_wr_n_q, lcd_wr_n_d;
    logic             lcd_rd_n_q, lcd_rd_n_d;
    logic             lcd_rst_n_q, lcd_rst_n_d;
    logic [DW-1:0]    lcd_db_out_q, lcd_db_out_d;
    logic             lcd_db_oe_q, lcd_db_oe_d;

    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_done;

    lcd_phase_timer #(
        .CW      (CW),
        .RST_VAL (LD_RST_LO)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        rep_d        = rep_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        lcd_rs_d     = lcd_rs_q;
        lcd_db_out_d = lcd_db_out_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        case (state_q)
            RST_LO: begin
                if (tmr_done) begin
                    state_d  = RST_WT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RST_WT;
                end
            end
            RST_WT: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    lcd_rs_d = cmd_rs;
                    tmr_load = 1'b1;
                    if (cmd_rd) begin
                        state_d = RD_LO;
                        tmr_val = LD_RD_LO;
                    end else begin
                        state_d      = WR_LO;
                        tmr_val      = LD_WR_LO;
                        lcd_db_out_d = cmd_data;
                        rep_d        = cmd_rep;
                    end
                end
            end
            WR_LO: begin
                if (tmr_done) begin
                    state_d  = WR_HI;
                    tmr_load = 1'b1;
                    tmr_val  = LD_WR_HI;
                end
            end
            WR_HI: begin
                // Remaining-beat count only decrements when nonzero, so all-ones cannot wrap.
                if (tmr_done) begin
                    if (rep_q != '0) begin
                        state_d  = WR_LO;
                        rep_d    = rep_q - {{(REP_W-1){1'b0}}, 1'b1};
                        tmr_load = 1'b1;
                        tmr_val  = LD_WR_LO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD_LO: begin
                if (tmr_done) begin
                    state_d    = RD_HI;
                    rd_data_d  = lcd_db_in;
                    rd_valid_d = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_RD_HI;
                end
            end
            RD_HI: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = RST_LO;
                tmr_load = 1'b1;
                tmr_val  = LD_RST_LO;
            end
        endcase

        // Bus strobes are decoded from the next state so they register in step with it.
        lcd_rst_n_d = (state_d != RST_LO);
        lcd_cs_n_d  = !(state_d inside {WR_LO, WR_HI, RD_LO, RD_HI});
        lcd_wr_n_d  = (state_d != WR_LO);
        lcd_rd_n_d  = (state_d != RD_LO);
        lcd_db_oe_d = (state_d inside {WR_LO, WR_HI});
        init_done_d = init_done_q | (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_LO;
            rep_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            init_done_q  <= 1'b0;
            lcd_cs_n_q   <= 1'b1;
            lcd_rs_q     <= RS_CMD;
            lcd_wr_n_q   <= 1'b1;
            lcd_rd_n_q   <= 1'b1;
            lcd_rst_n_q  <= 1'b0;
            lcd_db_out_q <= '0;
            lcd_db_oe_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rep_q        <= rep_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            init_done_q  <= init_done_d;
            lcd_cs_n_q   <= lcd_cs_n_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_wr_n_q   <= lcd_wr_n_d;
            lcd_rd_n_q   <= lcd_rd_n_d;
            lcd_rst_n_q  <= lcd_rst_n_d;
            lcd_db_out_q <= lcd_db_out_d;
            lcd_db_oe_q  <= lcd_db_oe_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign init_done  = init_done_q;
    assign lcd_cs_n   = lcd_cs_n_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_wr_n   = lcd_wr_n_q;
    assign lcd_rd_n   = lcd_rd_n_q;
    assign lcd_rst_n  = lcd_rst_n_q;
    assign lcd_db_out = lcd_db_out_q;
    assign lcd_db_oe  = lcd_db_oe_q;

endmodule

// File: tb/tb_lcd_bus8080.sv
// Randomized scoreboard bench for lcd_bus8080 (16-bit default instance plus an 8-bit narrow-count instance).
module tb_lcd_bus8080;
    import lcd8080_pkg::*;

    localparam int WR_LOW   = 2;
    localparam int WR_HIGH  = 2;
    localparam int RD_LOW   = 4;
    localparam int RD_HIGH  = 4;
    localparam int RST_LOW  = 10;
    localparam int RST_WAIT = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        cmd_valid, cmd_ready, cmd_rs, cmd_rd;
    logic [15:0] cmd_data;
    logic [16:0] cmd_rep;
    logic        rd_valid, busy, init_done;
    logic [15:0] rd_data;
    logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_db_oe;
    logic [15:0] lcd_db_out, lcd_db_in;

    lcd_bus8080 u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs), .cmd_rd(cmd_rd),
        .cmd_data(cmd_data), .cmd_rep(cmd_rep),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .init_done(init_done),
        .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
        .lcd_rst_n(lcd_rst_n), .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe),
        .lcd_db_in(lcd_db_in)
    );

    // 8-bit instance with a 3-bit repeat count so the all-ones case is reachable
    logic       c8_valid, c8_ready, c8_rs, c8_rd;
    logic [7:0] c8_data;
    logic [2:0] c8_rep;
    logic       r8_valid, busy8, init8;
    logic [7:0] r8_data;
    logic       cs8_n, rs8, wr8_n, rd8_n, rst8_n, oe8;
    logic [7:0] db8_out, db8_in;

    lcd_bus8080 #(.DW(8), .REP_W(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c8_valid), .cmd_ready(c8_ready), .cmd_rs(c8_rs), .cmd_rd(c8_rd),
        .cmd_data(c8_data), .cmd_rep(c8_rep),
        .rd_valid(r8_valid), .rd_data(r8_data), .busy(busy8), .init_done(init8),
        .lcd_cs_n(cs8_n), .lcd_rs(rs8), .lcd_wr_n(wr8_n), .lcd_rd_n(rd8_n),
        .lcd_rst_n(rst8_n), .lcd_db_out(db8_out), .lcd_db_oe(oe8),
        .lcd_db_in(db8_in)
    );

    typedef struct {
        bit          is_rd;
        bit          rs;
        logic [15:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    cs_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops expected bus events as the DUT produces them
    int wr_run = 0, rd_run = 0, cs_run = 0;
    bit prev_wr = 1'b1, prev_rv = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_run  = 0;
            rd_run  = 0;
            cs_run  = 0;
            prev_wr = 1'b1;
            prev_rv = 1'b0;
        end else begin
            chk("wr_rd_not_both_low", 32'(lcd_wr_n | lcd_rd_n), 32'd1);
            if (!lcd_rd_n) chk("oe_off_while_rd_low", 32'(lcd_db_oe), 32'd0);
            if (!lcd_cs_n) chk("busy_while_cs_low", 32'(busy), 32'd1);

            if (!lcd_wr_n && prev_wr) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_wr_beat");
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_kind_write", 32'(b.is_rd), 32'd0);
                    chk("wr_rs", 32'(lcd_rs), 32'(b.rs));
                    chk("wr_db", 32'(lcd_db_out), 32'(b.data));
                    chk("wr_oe", 32'(lcd_db_oe), 32'd1);
                end
            end
            prev_wr = lcd_wr_n;

            if (!lcd_wr_n) wr_run++;
            else if (wr_run > 0) begin
                chk("wr_low_width", 32'(wr_run), 32'(WR_LOW));
                wr_run = 0;
            end

            if (!lcd_rd_n) rd_run++;
            else if (rd_run > 0) begin
                chk("rd_low_width", 32'(rd_run), 32'(RD_LOW));
                rd_run = 0;
            end

            if (!lcd_cs_n) cs_run++;
            else if (cs_run > 0) begin
                if (cs_q.size() == 0) fail_now("unexpected_cs_window");
                else chk("cs_low_cycles", 32'(cs_run), 32'(cs_q.pop_front()));
                cs_run = 0;
            end

            if (rd_valid) begin
                chk("rd_valid_single_cycle", 32'(prev_rv), 32'd0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rd_valid");
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_kind_read", 32'(b.is_rd), 32'd1);
                    chk("rd_data", 32'(rd_data), 32'(b.data));
                end
            end
            prev_rv = rd_valid;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_lcd_rst_n"}, 32'(lcd_rst_n), 32'd0);
        chk({tag, "_lcd_cs_n"}, 32'(lcd_cs_n), 32'd1);
        chk({tag, "_lcd_wr_n"}, 32'(lcd_wr_n), 32'd1);
        chk({tag, "_lcd_rd_n"}, 32'(lcd_rd_n), 32'd1);
        chk({tag, "_lcd_rs"}, 32'(lcd_rs), 32'(RS_CMD));
        chk({tag, "_lcd_db_out"}, 32'(lcd_db_out), 32'd0);
        chk({tag, "_lcd_db_oe"}, 32'(lcd_db_oe), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    // Called #1 after a rising edge, just after rst_n has been released.
    task automatic check_init_seq();
        int n = 0;
        int m = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!lcd_rst_n && n < 100);
        chk("panel_rst_low_cycles", 32'(n), 32'(RST_LOW));
        chk("init_done_low_during_wait", 32'(init_done), 32'd0);
        do begin
            @(posedge clk); #1;
            m++;
        end while (!cmd_ready && m < 200);
        chk("rst_wait_cycles", 32'(m), 32'(RST_WAIT));
        chk("init_done_after_seq", 32'(init_done), 32'd1);
    endtask

    task automatic send(input bit rd, input bit rs, input logic [15:0] d,
                        input int rep, input logic [15:0] din);
        int t = 0;
        while (!cmd_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_ready_timeout");
            return;
        end
        if (rd) begin
            lcd_db_in = din;
            exp_q.push_back('{is_rd: 1'b1, rs: rs, data: din});
            cs_q.push_back(RD_LOW + RD_HIGH);
        end else begin
            for (int i = 0; i <= rep; i++) exp_q.push_back('{is_rd: 1'b0, rs: rs, data: d});
            cs_q.push_back((rep + 1) * (WR_LOW + WR_HIGH));
        end
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_data  = d;
        cmd_rep   = 17'(rep);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = 16'($urandom);
        cmd_rep   = 17'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (!(cmd_ready && exp_q.size() == 0 && cs_q.size() == 0) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) fail_now("drain_timeout");
    endtask

    task automatic burst8(input logic [7:0] d, input int rep);
        int  t = 0;
        int  pulses = 0;
        int  cslen = 0;
        bit  prev = 1'b1;
        while (!c8_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!c8_ready) begin
            fail_now("dw8_ready_timeout");
            return;
        end
        c8_valid = 1'b1;
        c8_rd    = 1'b0;
        c8_rs    = RS_DATA;
        c8_data  = d;
        c8_rep   = 3'(rep);
        @(posedge clk); #1;
        c8_valid = 1'b0;
        c8_data  = 8'($urandom);
        t = 0;
        while (t < 400) begin
            if (!wr8_n && prev) begin
                pulses++;
                chk("dw8_db_on_pulse", 32'(db8_out), 32'(d));
            end
            prev = wr8_n;
            if (!cs8_n) cslen++;
            else if (cslen > 0) break;
            @(posedge clk); #1;
            t++;
        end
        chk("dw8_pulse_count", 32'(pulses), 32'(rep + 1));
        chk("dw8_cs_low_cycles", 32'(cslen), 32'((rep + 1) * (WR_LOW + WR_HIGH)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_rs    = 1'b0;
        cmd_rd    = 1'b0;
        cmd_data  = '0;
        cmd_rep   = '0;
        lcd_db_in = '0;
        c8_valid  = 1'b0;
        c8_rs     = 1'b0;
        c8_rd     = 1'b0;
        c8_data   = '0;
        c8_rep    = '0;
        db8_in    = '0;

        #23;
        check_reset_vals("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_init_seq();

        send(1'b0, RS_CMD, 16'h002C, 0, 16'h0);
        wait_drain();
        send(1'b0, RS_DATA, 16'hF800, 3, 16'h0);
        wait_drain();
        send(1'b1, RS_DATA, 16'h0, 0, 16'h9341);
        wait_drain();
        chk("rd_data_held", 32'(rd_data), 32'h9341);

        for (int i = 0; i < 40; i++) begin
            bit rd;
            rd = ($urandom_range(0, 3) == 0);
            send(rd, 1'($urandom), 16'($urandom), $urandom_range(0, 5), 16'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
        wait_drain();

        // Abort a burst mid-flight and confirm the panel sequence restarts cleanly
        send(1'b0, RS_DATA, 16'h1234, 3, 16'h0);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        cs_q.delete();
        #1;
        check_reset_vals("abort");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_init_seq();
        chk("no_stale_beats", 32'(exp_q.size()), 32'd0);
        send(1'b0, RS_CMD, 16'h0036, 1, 16'h0);
        wait_drain();
        send(1'b1, RS_CMD, 16'h0, 0, 16'h5AA5);
        wait_drain();

        burst8(8'hA5, 1);
        burst8(8'($urandom), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
